// File: rtl/vga_sync_gen.sv
// VGA sync generator: registers sync, blanking and position outputs from an upstream hcount
// and tracks the line number. Define FRAME_COUNT_EN to build the completed-frame counter.
module vga_sync_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clock_25_mhz,
  input  logic       reset,
  input  logic [9:0] hcount,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_end,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [9:0] v;
  logic       line_last;

  // Out-of-range hcount never matches H_LAST, so it cannot advance the line.
  assign line_last = (hcount == H_LAST);

  always_ff @(posedge clock_25_mhz or posedge reset) begin
    if (reset) begin
      v           <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // A corrupted line number (>= V_TOTAL) also wraps to 0 at the line end.
      if (line_last) begin
        v <= (v >= V_LAST) ? '0 : v + 10'd1;
      end
      pixel_x     <= hcount;
      pixel_y     <= v;
      hsync       <= ~((hcount >= HS_FIRST) && (hcount <= HS_LAST));
      vsync       <= ~((v >= VS_FIRST) && (v <= VS_LAST));
      video_on    <= (hcount < H_VIS) && (v < V_VIS);
      line_end    <= line_last;
      frame_start <= (hcount == 10'd0) && (v == 10'd0);
    end
  end

`ifdef FRAME_COUNT_EN
  logic [7:0] frame_count_q;

  always_ff @(posedge clock_25_mhz or posedge reset) begin
    if (reset) begin
      frame_count_q <= '0;
    end else if (line_last && (v == V_LAST)) begin
      frame_count_q <= frame_count_q + 8'd1;
    end
  end

  assign frame_count = frame_count_q;
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: a reference model pushes expected outputs per driven
// hcount and each scenario task pops and compares them one cycle later.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] px;
    logic [9:0] py;
    logic       hs;
    logic       vs;
    logic       von;
    logic       le;
    logic       fs;
    logic [7:0] fc;
  } out_t;

  localparam out_t RST_OUT = '{px: 10'd0, py: 10'd0, hs: 1'b1, vs: 1'b1, von: 1'b0,
                               le: 1'b0, fs: 1'b0, fc: 8'd0};

  logic       clock_25_mhz = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] hcount = 10'd0;
  logic       hsync, vsync, video_on, line_end, frame_start;
  logic [9:0] pixel_x, pixel_y;
  logic [7:0] frame_count;
  out_t       obs;

  out_t       sb[$];
  logic [9:0] mv = 10'd0;
  logic [7:0] mfc = 8'd0;
  int         checks = 0;
  int         errors = 0;

  vga_sync_gen dut (
    .clock_25_mhz(clock_25_mhz),
    .reset       (reset),
    .hcount      (hcount),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .line_end    (line_end),
    .frame_start (frame_start),
    .frame_count (frame_count)
  );

  always #20 clock_25_mhz = ~clock_25_mhz;

  assign obs = {pixel_x, pixel_y, hsync, vsync, video_on, line_end, frame_start, frame_count};

  // Drive one hcount, push the model's prediction, and advance past the sampling edge.
  task automatic cycle(input logic [9:0] h);
    out_t e;
    hcount = h;
    e.px  = h;
    e.py  = mv;
    e.hs  = !((h >= 10'd656) && (h <= 10'd751));
    e.vs  = !((mv >= 10'd490) && (mv <= 10'd491));
    e.von = (h < 10'd640) && (mv < 10'd480);
    e.le  = (h == 10'd799);
    e.fs  = (h == 10'd0) && (mv == 10'd0);
    if (h == 10'd799) begin
`ifdef FRAME_COUNT_EN
      if (mv == 10'd524) mfc = mfc + 8'd1;
`endif
      mv = (mv >= 10'd524) ? 10'd0 : mv + 10'd1;
    end
    e.fc = mfc;
    sb.push_back(e);
    @(posedge clock_25_mhz);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock_25_mhz);
    #1;
    checks++;
    if (obs !== RST_OUT) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", obs, RST_OUT);
    end
  endtask

  task automatic test_first_line();
    out_t e;
    reset = 1'b0;
    cycle(10'd0);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL first_pixel: got %h want %h", obs, e);
    end
    checks++;
    if ({frame_start, video_on, pixel_x, pixel_y} !== {1'b1, 1'b1, 20'd0}) begin
      errors++;
      $display("FAIL first_pixel_flags: got fs=%b von=%b x=%0d y=%0d want fs=1 von=1 x=0 y=0",
               frame_start, video_on, pixel_x, pixel_y);
    end
    for (int h = 1; h < 800; h++) begin
      cycle(10'(h));
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL line0 h=%0d: got %h want %h", h, obs, e);
      end
    end
  endtask

  task automatic test_hsync();
    out_t e;
    repeat (9) begin
      cycle(10'd799);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL hsync_adv: got %h want %h", obs, e);
      end
    end
    cycle(10'd656);
    e = sb.pop_front();
    checks++;
    if (obs !== e || hsync !== 1'b0 || pixel_y !== 10'd10) begin
      errors++;
      $display("FAIL hsync_assert: got %h (hsync=%b) want %h (hsync=0)", obs, hsync, e);
    end
    cycle(10'd751);
    e = sb.pop_front();
    checks++;
    if (obs !== e || hsync !== 1'b0) begin
      errors++;
      $display("FAIL hsync_last: got %h (hsync=%b) want %h (hsync=0)", obs, hsync, e);
    end
    cycle(10'd752);
    e = sb.pop_front();
    checks++;
    if (obs !== e || hsync !== 1'b1) begin
      errors++;
      $display("FAIL hsync_release: got %h (hsync=%b) want %h (hsync=1)", obs, hsync, e);
    end
    cycle(10'd799);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL hsync_line_end: got %h want %h", obs, e);
    end
  endtask

  task automatic test_vsync();
    out_t       e;
    logic [9:0] ln;
    while (mv != 10'd490) begin
      cycle(10'd799);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL vsync_adv: got %h want %h", obs, e);
      end
    end
    for (int l = 0; l < 3; l++) begin
      ln = mv;
      for (int h = 0; h < 800; h++) begin
        cycle(10'(h));
        e = sb.pop_front();
        checks++;
        if (obs !== e || vsync !== (ln == 10'd492) || video_on !== 1'b0) begin
          errors++;
          $display("FAIL vsync line=%0d h=%0d: got %h (vs=%b von=%b) want %h", ln, h, obs,
                   vsync, video_on, e);
        end
      end
    end
    while (mv != 10'd524) begin
      cycle(10'd100);
      e = sb.pop_front();
      checks++;
      if (obs !== e || video_on !== 1'b0) begin
        errors++;
        $display("FAIL blank_visible_h: got %h want %h", obs, e);
      end
      cycle(10'd799);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL blank_adv: got %h want %h", obs, e);
      end
    end
  endtask

  task automatic test_frame_boundary();
    out_t       e;
    logic [7:0] want_fc;
`ifdef FRAME_COUNT_EN
    want_fc = 8'd1;
`else
    want_fc = 8'd0;
`endif
    cycle(10'd798);
    e = sb.pop_front();
    checks++;
    if (obs !== e || line_end !== 1'b0 || frame_count !== 8'd0) begin
      errors++;
      $display("FAIL pre_boundary: got %h want %h", obs, e);
    end
    cycle(10'd799);
    e = sb.pop_front();
    checks++;
    if (obs !== e || line_end !== 1'b1 || pixel_y !== 10'd524 || frame_count !== want_fc) begin
      errors++;
      $display("FAIL boundary_line_end: got %h (fc=%0d) want %h (fc=%0d)", obs, frame_count,
               e, want_fc);
    end
    cycle(10'd0);
    e = sb.pop_front();
    checks++;
    if (obs !== e || frame_start !== 1'b1 || pixel_y !== 10'd0 || line_end !== 1'b0) begin
      errors++;
      $display("FAIL boundary_frame_start: got %h want %h", obs, e);
    end
  endtask

  task automatic test_frame_wrap();
    out_t e;
    int   nframes;
`ifdef FRAME_COUNT_EN
    nframes = 255;
`else
    nframes = 3;
`endif
    for (int f = 0; f < nframes; f++) begin
      for (int l = 0; l < 525; l++) begin
        cycle(10'd799);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL frame_run f=%0d l=%0d: got %h want %h", f, l, obs, e);
        end
      end
    end
    checks++;
    if (frame_count !== 8'd0 || mfc !== 8'd0) begin
      errors++;
      $display("FAIL frame_count_wrap: got %0d want 0", frame_count);
    end
  endtask

  task automatic test_reset_mid();
    out_t e;
    while (mv != 10'd200) begin
      cycle(10'd799);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL mid_adv: got %h want %h", obs, e);
      end
    end
    cycle(10'd300);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL mid_pre_reset: got %h want %h", obs, e);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== RST_OUT) begin
      errors++;
      $display("FAIL mid_reset_async: got %h want %h", obs, RST_OUT);
    end
    for (int h = 301; h < 304; h++) begin
      hcount = 10'(h);
      @(posedge clock_25_mhz);
      #1;
      checks++;
      if (obs !== RST_OUT) begin
        errors++;
        $display("FAIL mid_reset_hold h=%0d: got %h want %h", h, obs, RST_OUT);
      end
    end
    reset = 1'b0;
    mv = 10'd0;
    mfc = 8'd0;
    for (int h = 304; h < 800; h++) begin
      cycle(10'(h));
      e = sb.pop_front();
      checks++;
      if (obs !== e || pixel_y !== 10'd0) begin
        errors++;
        $display("FAIL partial_line h=%0d: got %h want %h", h, obs, e);
      end
    end
    cycle(10'd0);
    e = sb.pop_front();
    checks++;
    if (obs !== e || pixel_y !== 10'd1) begin
      errors++;
      $display("FAIL after_partial: got %h want %h", obs, e);
    end
  endtask

  task automatic test_out_of_range();
    out_t       e;
    logic [9:0] ln;
    ln = mv;
    cycle(10'd5);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL oor_pre: got %h want %h", obs, e);
    end
    repeat (2) begin
      cycle(10'd900);
      e = sb.pop_front();
      checks++;
      if (obs !== e || {hsync, video_on, line_end, frame_start} !== 4'b1000) begin
        errors++;
        $display("FAIL oor_outputs: got %h want %h", obs, e);
      end
    end
    cycle(10'd6);
    e = sb.pop_front();
    checks++;
    if (obs !== e || pixel_y !== ln) begin
      errors++;
      $display("FAIL oor_v_held: got y=%0d want y=%0d", pixel_y, ln);
    end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_hsync();
    test_vsync();
    test_frame_boundary();
    test_frame_wrap();
    test_reset_mid();
    test_out_of_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
